// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b subtractor, LSB first, one bit per clock
// Flags and result are latched on the final bit and held until the next completion or reset.
module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int CW = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] a_sh;
  logic [NUM_BITS-1:0] b_sh;
  logic [NUM_BITS-1:0] res;
  logic [CW-1:0]       cnt;
  logic                br;
  logic                a_msb;
  logic                b_msb;
  logic                bit_d;
  logic                br_next;
  logic [NUM_BITS-1:0] res_next;

  assign bit_d    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_next = {bit_d, res[NUM_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(NUM_BITS - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= br_next;
            // bit_d is the result MSB produced on this final edge
            overflow   <= (a_msb != b_msb) && (bit_d != a_msb);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation
          if (start == 1'b1) begin
            state <= CALC;
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[NUM_BITS-1];
            b_msb <= b[NUM_BITS-1];
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst && $isunknown(start))
      $error("serial_subtractor: start is not 0/1");
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - table-driven and scoreboard bench for serial_subtractor
module tb_serial_subtractor;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  serial_subtractor #(.NUM_BITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t r;
    r.d  = x - y;
    r.bo = (x < y);
    r.ov = (x[7] != y[7]) && (r.d[7] != x[7]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, e.d});
        chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
      end
    end
  end

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input exp_t e);
    int bad = 0;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      if (!busy || done) bad++;
      @(negedge clk);
    end
    chk("busy_window", bad, 0);
    chk("done_latency", {31'd0, done}, 1);
    chk("busy_in_done", {31'd0, busy}, 0);
    @(negedge clk);
    chk("done_drop", {31'd0, done}, 0);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", {31'd0, done}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    int   n;
    int   t_prev;
    logic [7:0] x, y;

    tbl[0] = '{8'h0A, 8'h03, '{8'h07, 1'b0, 1'b0}};
    tbl[1] = '{8'h03, 8'h0A, '{8'hF9, 1'b1, 1'b0}};
    tbl[2] = '{8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1}};
    tbl[3] = '{8'h55, 8'h55, '{8'h00, 1'b0, 1'b0}};
    tbl[4] = '{8'h00, 8'hFF, '{8'h01, 1'b1, 1'b0}};
    tbl[5] = '{8'h7F, 8'h80, '{8'hFF, 1'b1, 1'b1}};
    tbl[6] = '{8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b1}};
    tbl[7] = '{8'hFF, 8'h01, '{8'hFE, 1'b0, 1'b0}};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_diff", {24'd0, diff}, 0);
    chk("rst_borrow", {31'd0, borrow_out}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].e);
    for (int i = 0; i < 4; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      run_op(x, y, model(x, y));
    end

    // start and operand changes during CALC are ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    sb.push_back('{8'h0F, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (10) @(negedge clk);
    chk("midcalc_hold_diff", {24'd0, diff}, 32'h0F);

    // reset during the 4th CALC cycle aborts without a done pulse
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_diff", {24'd0, diff}, 0);
    chk("abort_borrow", {31'd0, borrow_out}, 0);
    chk("abort_overflow", {31'd0, overflow}, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", {31'd0, busy}, 0);
    run_op(8'h20, 8'h10, '{8'h10, 1'b0, 1'b0});

    // start held high: back-to-back operations every N+1 cycles
    @(negedge clk);
    a = 8'h0A; b = 8'h03; start = 1'b1;
    repeat (3) sb.push_back('{8'h07, 1'b0, 1'b0});
    bad = 0;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done && n < 30) begin
        if (k > 0 && diff !== 8'h07) bad++;
        @(negedge clk);
        n++;
      end
      chk("held_done_timeout", {31'd0, done}, 1);
      if (k > 0) chk("held_period", cyc - t_prev, N + 1);
      t_prev = cyc;
      if (k == 2) start = 1'b0;
      else @(negedge clk);
    end
    chk("held_diff_stable", bad, 0);

    repeat (12) @(negedge clk);
    chk("held_idle_busy", {31'd0, busy}, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
